// File: rtl/wishbone_ram_arbiter_if.sv
// Bus bundle between the two Wishbone masters, the arbiter and the SRAM address-decode mux.
// The slave modport is the arbiter's view; the master modport is the surrounding system's view.
interface wishbone_ram_arbiter_if;
    logic        wbs_m0_stb_i;
    logic        wbs_m0_cyc_i;
    logic        wbs_m0_we_i;
    logic [3:0]  wbs_m0_sel_i;
    logic [31:0] wbs_m0_dat_i;
    logic [31:0] wbs_m0_adr_i;
    logic        wbs_m0_ack_o;
    logic [31:0] wbs_m0_dat_o;

    logic        wbs_m1_stb_i;
    logic        wbs_m1_cyc_i;
    logic        wbs_m1_we_i;
    logic [3:0]  wbs_m1_sel_i;
    logic [31:0] wbs_m1_dat_i;
    logic [31:0] wbs_m1_adr_i;
    logic        wbs_m1_ack_o;
    logic [31:0] wbs_m1_dat_o;

    logic        wbs_dfp_stb_o;
    logic        wbs_dfp_cyc_o;
    logic        wbs_dfp_we_o;
    logic [3:0]  wbs_dfp_sel_o;
    logic [31:0] wbs_dfp_dat_o;
    logic [31:0] wbs_dfp_adr_o;
    logic        wbs_dfp_ack_i;
    logic [31:0] wbs_dfp_dat_i;

    modport slave (
        input  wbs_m0_stb_i, wbs_m0_cyc_i, wbs_m0_we_i, wbs_m0_sel_i, wbs_m0_dat_i, wbs_m0_adr_i,
        output wbs_m0_ack_o, wbs_m0_dat_o,
        input  wbs_m1_stb_i, wbs_m1_cyc_i, wbs_m1_we_i, wbs_m1_sel_i, wbs_m1_dat_i, wbs_m1_adr_i,
        output wbs_m1_ack_o, wbs_m1_dat_o,
        output wbs_dfp_stb_o, wbs_dfp_cyc_o, wbs_dfp_we_o, wbs_dfp_sel_o, wbs_dfp_dat_o, wbs_dfp_adr_o,
        input  wbs_dfp_ack_i, wbs_dfp_dat_i
    );

    modport master (
        output wbs_m0_stb_i, wbs_m0_cyc_i, wbs_m0_we_i, wbs_m0_sel_i, wbs_m0_dat_i, wbs_m0_adr_i,
        input  wbs_m0_ack_o, wbs_m0_dat_o,
        output wbs_m1_stb_i, wbs_m1_cyc_i, wbs_m1_we_i, wbs_m1_sel_i, wbs_m1_dat_i, wbs_m1_adr_i,
        input  wbs_m1_ack_o, wbs_m1_dat_o,
        input  wbs_dfp_stb_o, wbs_dfp_cyc_o, wbs_dfp_we_o, wbs_dfp_sel_o, wbs_dfp_dat_o, wbs_dfp_adr_o,
        output wbs_dfp_ack_i, wbs_dfp_dat_i
    );
endinterface

// File: rtl/wishbone_ram_arbiter.sv
// Two-master Wishbone arbiter for the SRAM port with per-transfer ack watchdog.
// Latency: grant one cycle after request; dfp path combinational from registered grant.
// Backpressure: non-owner waits until owner drops cyc; optional WB_ARB_ROUND_ROBIN_EN alternates ties.
module wishbone_ram_arbiter #(
    parameter int          TIMEOUT_CYCLES = 255,
    parameter int          CNT_W          = 8,
    parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    wishbone_ram_arbiter_if.slave  bus,
    output logic [1:0]             grant_o,
    output logic                   timeout_o
);
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_OWN0    = 2'd1,
        ST_OWN1    = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    localparam bit             LP_WD_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] LP_LAST = LP_WD_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    state_t           r_state;
    logic [1:0]       r_grant;
    logic [CNT_W-1:0] r_cnt;
`ifdef WB_ARB_ROUND_ROBIN_EN
    logic             r_rr_ptr;
`endif

    logic             w_own0, w_own1, w_own;
    logic             w_stb, w_cyc, w_we;
    logic [3:0]       w_sel;
    logic [31:0]      w_dat, w_adr;
    logic             w_req0, w_req1, w_pick0;
    logic             w_wait, w_fire, w_ack;
    logic [CNT_W-1:0] w_cnt_nxt;

    // Reset low blanks the granted path in the same cycle so an aborted transfer never sees an ack.
    assign w_own0 = wb_rst_i & r_grant[0];
    assign w_own1 = wb_rst_i & r_grant[1];
    assign w_own  = w_own0 | w_own1;

    always_comb begin
        w_stb = 1'b0;
        w_cyc = 1'b0;
        w_we  = 1'b0;
        w_sel = '0;
        w_dat = '0;
        w_adr = '0;
        if (w_own0) begin
            w_stb = bus.wbs_m0_stb_i;
            w_cyc = bus.wbs_m0_cyc_i;
            w_we  = bus.wbs_m0_we_i;
            w_sel = bus.wbs_m0_sel_i;
            w_dat = bus.wbs_m0_dat_i;
            w_adr = bus.wbs_m0_adr_i;
        end else if (w_own1) begin
            w_stb = bus.wbs_m1_stb_i;
            w_cyc = bus.wbs_m1_cyc_i;
            w_we  = bus.wbs_m1_we_i;
            w_sel = bus.wbs_m1_sel_i;
            w_dat = bus.wbs_m1_dat_i;
            w_adr = bus.wbs_m1_adr_i;
        end
    end

    // A real ack in the last allowed cycle wins over the synthetic error ack.
    assign w_wait    = LP_WD_EN && w_own && w_stb && !bus.wbs_dfp_ack_i;
    assign w_fire    = w_wait && (r_cnt == LP_LAST);
    assign w_cnt_nxt = w_wait ? (r_cnt + CNT_W'(1)) : '0;
    assign w_ack     = bus.wbs_dfp_ack_i | w_fire;

    assign bus.wbs_dfp_stb_o = w_stb & ~w_fire;
    assign bus.wbs_dfp_cyc_o = w_cyc & ~w_fire;
    assign bus.wbs_dfp_we_o  = w_we;
    assign bus.wbs_dfp_sel_o = w_sel;
    assign bus.wbs_dfp_dat_o = w_dat;
    assign bus.wbs_dfp_adr_o = w_adr;

    assign bus.wbs_m0_ack_o = w_own0 & w_ack;
    assign bus.wbs_m1_ack_o = w_own1 & w_ack;
    assign bus.wbs_m0_dat_o = w_own0 ? (w_fire ? ERR_DATA : bus.wbs_dfp_dat_i) : '0;
    assign bus.wbs_m1_dat_o = w_own1 ? (w_fire ? ERR_DATA : bus.wbs_dfp_dat_i) : '0;

    assign timeout_o = w_fire;
    assign grant_o   = r_grant;

    assign w_req0 = bus.wbs_m0_cyc_i & bus.wbs_m0_stb_i;
    assign w_req1 = bus.wbs_m1_cyc_i & bus.wbs_m1_stb_i;
`ifdef WB_ARB_ROUND_ROBIN_EN
    assign w_pick0 = w_req0 & (~w_req1 | ~r_rr_ptr);
`else
    assign w_pick0 = w_req0;
`endif

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            r_state  <= ST_IDLE;
            r_grant  <= 2'b00;
            r_cnt    <= '0;
`ifdef WB_ARB_ROUND_ROBIN_EN
            r_rr_ptr <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= '0;
                    if (w_pick0) begin
                        r_state <= ST_OWN0;
                        r_grant <= 2'b01;
                    end else if (w_req1) begin
                        r_state <= ST_OWN1;
                        r_grant <= 2'b10;
                    end
                end
                ST_OWN0: begin
                    if (!bus.wbs_m0_cyc_i || w_fire) begin
                        r_state  <= ST_RELEASE;
                        r_grant  <= 2'b00;
                        r_cnt    <= '0;
`ifdef WB_ARB_ROUND_ROBIN_EN
                        r_rr_ptr <= 1'b1;
`endif
                    end else begin
                        r_cnt <= w_cnt_nxt;
                    end
                end
                ST_OWN1: begin
                    if (!bus.wbs_m1_cyc_i || w_fire) begin
                        r_state  <= ST_RELEASE;
                        r_grant  <= 2'b00;
                        r_cnt    <= '0;
`ifdef WB_ARB_ROUND_ROBIN_EN
                        r_rr_ptr <= 1'b0;
`endif
                    end else begin
                        r_cnt <= w_cnt_nxt;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_grant <= 2'b00;
                    r_cnt   <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_wishbone_ram_arbiter.sv
// Directed bench for wishbone_ram_arbiter: per-cycle vector table plus watchdog and reset sequences.
module tb_wishbone_ram_arbiter;
    localparam logic [31:0] M0_ADR = 32'h3000_0010;
    localparam logic [31:0] M0_DAT = 32'hA0A0_0001;
    localparam logic [3:0]  M0_SEL = 4'hF;
    localparam logic [31:0] M1_ADR = 32'h3000_0020;
    localparam logic [31:0] M1_DAT = 32'hB1B1_0002;
    localparam logic [3:0]  M1_SEL = 4'h3;
`ifdef WB_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic       wb_clk_i = 1'b0;
    logic       wb_rst_i;
    logic [1:0] grant_o;
    logic       timeout_o;

    wishbone_ram_arbiter_if bus();

    wishbone_ram_arbiter #(
        .TIMEOUT_CYCLES(8),
        .CNT_W(8),
        .ERR_DATA(32'hDEAD_BEEF)
    ) dut (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .bus      (bus),
        .grant_o  (grant_o),
        .timeout_o(timeout_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    typedef struct {
        logic        m0c, m0s, m1c, m1s, we, ack;
        logic [31:0] rdat;
        logic [1:0]  g;
        logic        a0;
        logic [31:0] d0;
        logic        a1;
        logic [31:0] d1;
        logic        stb, cyc, to;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic add(input logic m0c, m0s, m1c, m1s, we, ack, input logic [31:0] rdat,
                       input logic [1:0] g, input logic a0, input logic [31:0] d0,
                       input logic a1, input logic [31:0] d1, input logic stb, cyc, to);
        vec_t v;
        v.m0c = m0c; v.m0s = m0s; v.m1c = m1c; v.m1s = m1s; v.we = we; v.ack = ack;
        v.rdat = rdat; v.g = g; v.a0 = a0; v.d0 = d0; v.a1 = a1; v.d1 = d1;
        v.stb = stb; v.cyc = cyc; v.to = to;
        vecs.push_back(v);
    endtask

    // Both masters request together and each does one write; f selects which one is served first.
    task automatic add_pair(input bit f, input logic [31:0] r1, input logic [31:0] r2);
        logic [1:0] g1, g2;
        g1 = f ? 2'b10 : 2'b01;
        g2 = f ? 2'b01 : 2'b10;
        add(1, 1, 1, 1, 1, 0, 0,  2'b00, 0, 0, 0, 0, 0, 0, 0);
        add(1, 1, 1, 1, 1, 1, r1, g1, !f, f ? 32'd0 : r1, f, f ? r1 : 32'd0, 1, 1, 0);
        add(f, f, !f, !f, 1, 0, 0, g1, 0, 0, 0, 0, 0, 0, 0);
        add(f, f, !f, !f, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        add(f, f, !f, !f, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        add(f, f, !f, !f, 1, 1, r2, g2, f, f ? r2 : 32'd0, !f, f ? 32'd0 : r2, 1, 1, 0);
        add(0, 0, 0, 0, 1, 0, 0,  g2, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 0, 0,  2'b00, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic drive(input vec_t v);
        bus.wbs_m0_cyc_i  = v.m0c;
        bus.wbs_m0_stb_i  = v.m0s;
        bus.wbs_m0_we_i   = v.we;
        bus.wbs_m1_cyc_i  = v.m1c;
        bus.wbs_m1_stb_i  = v.m1s;
        bus.wbs_m1_we_i   = v.we;
        bus.wbs_dfp_ack_i = v.ack;
        bus.wbs_dfp_dat_i = v.rdat;
    endtask

    task automatic check_vec(input int i, input vec_t v);
        logic [31:0] ea, ed;
        logic [3:0]  es;
        logic        ew;
        ea = (v.g == 2'b01) ? M0_ADR : (v.g == 2'b10) ? M1_ADR : 32'd0;
        ed = (v.g == 2'b01) ? M0_DAT : (v.g == 2'b10) ? M1_DAT : 32'd0;
        es = (v.g == 2'b01) ? M0_SEL : (v.g == 2'b10) ? M1_SEL : 4'd0;
        ew = (v.g != 2'b00) ? v.we : 1'b0;
        chk($sformatf("v%0d grant", i),   32'(grant_o),           32'(v.g));
        chk($sformatf("v%0d m0_ack", i),  32'(bus.wbs_m0_ack_o),  32'(v.a0));
        chk($sformatf("v%0d m0_dat", i),  bus.wbs_m0_dat_o,       v.d0);
        chk($sformatf("v%0d m1_ack", i),  32'(bus.wbs_m1_ack_o),  32'(v.a1));
        chk($sformatf("v%0d m1_dat", i),  bus.wbs_m1_dat_o,       v.d1);
        chk($sformatf("v%0d dfp_stb", i), 32'(bus.wbs_dfp_stb_o), 32'(v.stb));
        chk($sformatf("v%0d dfp_cyc", i), 32'(bus.wbs_dfp_cyc_o), 32'(v.cyc));
        chk($sformatf("v%0d dfp_we", i),  32'(bus.wbs_dfp_we_o),  32'(ew));
        chk($sformatf("v%0d dfp_adr", i), bus.wbs_dfp_adr_o,      ea);
        chk($sformatf("v%0d dfp_dat", i), bus.wbs_dfp_dat_o,      ed);
        chk($sformatf("v%0d dfp_sel", i), 32'(bus.wbs_dfp_sel_o), 32'(es));
        chk($sformatf("v%0d timeout", i), 32'(timeout_o),         32'(v.to));
    endtask

    // m0 read that the RAM never acks, or acks only in the eighth stb cycle.
    task automatic run_watchdog(input bit ack_last);
        bit seen;
        int pulses;
        string tag;
        seen   = 1'b0;
        pulses = 0;
        tag    = ack_last ? "wd_late_ack" : "wd_timeout";
        bus.wbs_m0_cyc_i  = 1'b1;
        bus.wbs_m0_stb_i  = 1'b1;
        bus.wbs_m0_we_i   = 1'b0;
        bus.wbs_dfp_dat_i = 32'hCAFE_F00D;
        for (int c = 0; c < 16; c++) begin
            bus.wbs_dfp_ack_i = ack_last && (c == 8);
            @(negedge wb_clk_i);
            if (timeout_o) pulses++;
            if (c == 1) chk({tag, " grant"}, 32'(grant_o), 32'h1);
            if (!seen && bus.wbs_m0_ack_o) begin
                seen = 1'b1;
                chk({tag, " ack_cycle"}, c, 8);
                chk({tag, " m0_dat"}, bus.wbs_m0_dat_o, ack_last ? 32'hCAFE_F00D : 32'hDEAD_BEEF);
                chk({tag, " timeout"}, 32'(timeout_o), ack_last ? 32'h0 : 32'h1);
                chk({tag, " dfp_cyc"}, 32'(bus.wbs_dfp_cyc_o), ack_last ? 32'h1 : 32'h0);
            end
            @(posedge wb_clk_i);
            #1;
            if (seen) begin
                bus.wbs_m0_cyc_i = 1'b0;
                bus.wbs_m0_stb_i = 1'b0;
            end
        end
        chk({tag, " ack_seen"}, 32'(seen), 32'h1);
        chk({tag, " pulses"}, pulses, ack_last ? 0 : 1);
        bus.wbs_m0_cyc_i  = 1'b0;
        bus.wbs_m0_stb_i  = 1'b0;
        bus.wbs_dfp_ack_i = 1'b0;
        bus.wbs_dfp_dat_i = 32'd0;
    endtask

    // Reset pulled low while m1 owns the bus and the RAM is acking.
    task automatic run_reset_abort();
        bus.wbs_m1_cyc_i = 1'b1;
        bus.wbs_m1_stb_i = 1'b1;
        bus.wbs_m1_we_i  = 1'b0;
        @(negedge wb_clk_i);
        @(posedge wb_clk_i);
        #1;
        @(negedge wb_clk_i);
        chk("rst_abort grant_before", 32'(grant_o), 32'h2);
        @(posedge wb_clk_i);
        #1;
        wb_rst_i          = 1'b0;
        bus.wbs_dfp_ack_i = 1'b1;
        bus.wbs_dfp_dat_i = 32'h7777_7777;
        @(negedge wb_clk_i);
        chk("rst_abort m1_ack_now", 32'(bus.wbs_m1_ack_o), 32'h0);
        @(posedge wb_clk_i);
        #1;
        @(negedge wb_clk_i);
        chk("rst_abort grant",   32'(grant_o),           32'h0);
        chk("rst_abort dfp_stb", 32'(bus.wbs_dfp_stb_o), 32'h0);
        chk("rst_abort dfp_cyc", 32'(bus.wbs_dfp_cyc_o), 32'h0);
        chk("rst_abort dfp_adr", bus.wbs_dfp_adr_o,      32'h0);
        chk("rst_abort dfp_dat", bus.wbs_dfp_dat_o,      32'h0);
        chk("rst_abort m1_ack",  32'(bus.wbs_m1_ack_o),  32'h0);
        chk("rst_abort m1_dat",  bus.wbs_m1_dat_o,       32'h0);
        chk("rst_abort m0_ack",  32'(bus.wbs_m0_ack_o),  32'h0);
        @(posedge wb_clk_i);
        #1;
        bus.wbs_m1_cyc_i  = 1'b0;
        bus.wbs_m1_stb_i  = 1'b0;
        bus.wbs_dfp_ack_i = 1'b0;
        wb_rst_i          = 1'b1;
        @(negedge wb_clk_i);
        chk("rst_abort idle_grant", 32'(grant_o), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_time_limit: simulation did not reach the summary");
        $fatal(1);
    end

    initial begin
        wb_rst_i          = 1'b0;
        bus.wbs_m0_adr_i  = M0_ADR;
        bus.wbs_m0_dat_i  = M0_DAT;
        bus.wbs_m0_sel_i  = M0_SEL;
        bus.wbs_m1_adr_i  = M1_ADR;
        bus.wbs_m1_dat_i  = M1_DAT;
        bus.wbs_m1_sel_i  = M1_SEL;
        bus.wbs_m0_cyc_i  = 1'b1;
        bus.wbs_m0_stb_i  = 1'b1;
        bus.wbs_m0_we_i   = 1'b0;
        bus.wbs_m1_cyc_i  = 1'b1;
        bus.wbs_m1_stb_i  = 1'b1;
        bus.wbs_m1_we_i   = 1'b0;
        bus.wbs_dfp_ack_i = 1'b1;
        bus.wbs_dfp_dat_i = 32'h5A5A_5A5A;

        // Single m0 read, RAM acks two cycles after dfp_stb.
        add(1, 1, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        add(1, 1, 0, 0, 0, 0, 0, 2'b01, 0, 0, 0, 0, 1, 1, 0);
        add(1, 1, 0, 0, 0, 0, 0, 2'b01, 0, 0, 0, 0, 1, 1, 0);
        add(1, 1, 0, 0, 0, 1, 32'h1234_5678, 2'b01, 1, 32'h1234_5678, 0, 0, 1, 1, 0);
        add(0, 0, 0, 0, 0, 0, 0, 2'b01, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        add_pair(RR, 32'h5555_0001, 32'h5555_0002);
        add_pair(RR, 32'h6666_0001, 32'h6666_0002);
        // m1 burst of four writes while m0 keeps requesting.
        add(0, 0, 1, 1, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        add(1, 1, 1, 1, 1, 1, 32'h1, 2'b10, 0, 0, 1, 32'h1, 1, 1, 0);
        add(1, 1, 1, 0, 1, 0, 0, 2'b10, 0, 0, 0, 0, 0, 1, 0);
        add(1, 1, 1, 1, 1, 1, 32'h2, 2'b10, 0, 0, 1, 32'h2, 1, 1, 0);
        add(1, 1, 1, 1, 1, 1, 32'h3, 2'b10, 0, 0, 1, 32'h3, 1, 1, 0);
        add(1, 1, 1, 1, 1, 1, 32'h4, 2'b10, 0, 0, 1, 32'h4, 1, 1, 0);
        add(1, 1, 0, 0, 1, 0, 0, 2'b10, 0, 0, 0, 0, 0, 0, 0);
        add(1, 1, 0, 0, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        add(1, 1, 0, 0, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        add(1, 1, 0, 0, 1, 1, 32'h5, 2'b01, 1, 32'h5, 0, 0, 1, 1, 0);
        add(0, 0, 0, 0, 1, 0, 0, 2'b01, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);

        repeat (2) @(posedge wb_clk_i);
        #1;
        @(negedge wb_clk_i);
        chk("reset grant",   32'(grant_o),           32'h0);
        chk("reset timeout", 32'(timeout_o),         32'h0);
        chk("reset dfp_stb", 32'(bus.wbs_dfp_stb_o), 32'h0);
        chk("reset dfp_cyc", 32'(bus.wbs_dfp_cyc_o), 32'h0);
        chk("reset dfp_adr", bus.wbs_dfp_adr_o,      32'h0);
        chk("reset m0_ack",  32'(bus.wbs_m0_ack_o),  32'h0);
        chk("reset m0_dat",  bus.wbs_m0_dat_o,       32'h0);
        chk("reset m1_ack",  32'(bus.wbs_m1_ack_o),  32'h0);
        chk("reset m1_dat",  bus.wbs_m1_dat_o,       32'h0);
        @(posedge wb_clk_i);
        #1;
        wb_rst_i = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i]);
            @(negedge wb_clk_i);
            check_vec(i, vecs[i]);
            @(posedge wb_clk_i);
            #1;
        end

        run_watchdog(1'b0);
        run_watchdog(1'b1);
        run_reset_abort();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/wishbone_ram_arbiter.md
Name: wishbone_ram_arbiter

Overview:
- Two-master Wishbone arbiter in front of the SRAM address-decode mux.
- Shares the single upward-facing RAM port between master 0 (management SoC Wishbone) and master 1 (on-chip test sequencer).
- Holds the grant for the owner's whole cyc and applies a per-transfer watchdog, so a missing SRAM ack cannot hang either master.

Parameters:
- TIMEOUT_CYCLES, 255: stb-without-ack cycles before a synthetic error ack; 0 disables the watchdog.
- CNT_W, 8: watchdog counter width; must satisfy TIMEOUT_CYCLES < 2**CNT_W.
- ERR_DATA, 32'hDEAD_BEEF: read data returned on a timed-out transfer.

Ports:
- wb_clk_i  in  1  sole clock.
- wb_rst_i  in  1  reset, synchronous, active-low.
- wbs_m0_stb_i, wbs_m0_cyc_i, wbs_m0_we_i  in  1 each  master 0 control.
- wbs_m0_sel_i  in  4  master 0 byte selects.
- wbs_m0_dat_i, wbs_m0_adr_i  in  32 each  master 0 write data and address.
- wbs_m0_ack_o  out  1  master 0 ack.
- wbs_m0_dat_o  out  32  master 0 read data.
- wbs_m1_*  same set and directions as m0, for master 1.
- wbs_dfp_stb_o, wbs_dfp_cyc_o, wbs_dfp_we_o  out  1 each  to RAM mux.
- wbs_dfp_sel_o  out  4  to RAM mux.
- wbs_dfp_dat_o, wbs_dfp_adr_o  out  32 each  to RAM mux.
- wbs_dfp_ack_i  in  1  from RAM mux.
- wbs_dfp_dat_i  in  32  from RAM mux.
- grant_o  out  2  one-hot current owner; 2'b00 when idle.
- timeout_o  out  1  one-cycle pulse when the watchdog fires.

Behaviour:
- Reset (wb_rst_i low at a clock edge): state IDLE, grant_o=0, counter=0, RR pointer=0. timeout_o, all dfp outputs and both m*_ack_o are 0; m*_dat_o are 0.
- States:
  - IDLE: grant_o=0.
  - OWN0 / OWN1: grant_o=01 / 10.
  - RELEASE: grant_o=0.
- Transitions:
  - IDLE -> OWN0 if m0_cyc & m0_stb; else -> OWN1 if m1_cyc & m1_stb. Fixed priority; m0 wins ties.
  - OWNx -> RELEASE when mx_cyc drops or the watchdog fires.
  - RELEASE -> IDLE unconditionally.
- Grant latency: a request sampled in IDLE at edge N sets grant at edge N+1. Minimum dfp_stb is one cycle after the master raises stb.
- Released bus: dfp outputs are low during RELEASE, which guarantees one dead cycle between owners.
- Downstream muxing while OWNx (combinational from registered grant):
  - dfp_{stb,cyc,we,sel,dat,adr} = master x's inputs.
  - mx_ack_o = dfp_ack_i.
  - mx_dat_o = dfp_dat_i.
  - The non-owner sees ack=0 and dat=0.
- Outside OWNx, all dfp outputs are 0.
- Burst: the owner keeps cyc high across several stb/ack pairs and retains the grant. The other master waits and has no starvation guarantee in fixed-priority mode.
- Watchdog:
  - Counter increments each OWN cycle with dfp_stb=1 and dfp_ack_i=0.
  - It clears on ack, on stb=0, and outside OWN.
  - When the counter equals TIMEOUT_CYCLES-1 and ack is still 0, that cycle is the timeout cycle: mx_ack_o=1, mx_dat_o=ERR_DATA, dfp_stb_o/dfp_cyc_o forced 0, timeout_o=1, next state RELEASE.
- Boundaries:
  - A real ack arriving in the timeout cycle takes precedence: normal ack, no timeout.
  - cyc dropping without stb while owning -> RELEASE.
  - A request from either master during RELEASE is held and granted on the next IDLE decision.
  - Reset asserted mid-transfer aborts immediately; no ack is issued to any master.
  - TIMEOUT_CYCLES=0: counter never fires.

Optional Feature:
- Macro: WB_ARB_ROUND_ROBIN_EN.
- Defined:
  - IDLE tie-break uses a 1-bit RR pointer. Pointer=0 prefers m0, pointer=1 prefers m1.
  - The pointer is set to the non-owner on each entry to RELEASE.
  - Simultaneous back-to-back requests therefore alternate owners.
- Undefined: fixed priority to m0; the pointer is not implemented.

Test Plan:
- Single m0 read at adr 32'h3000_0010, RAM acks 2 cycles after dfp_stb with 32'h1234_5678:
  - grant_o=01 one cycle after the request.
  - m0_ack_o=1 with m0_dat_o=32'h1234_5678.
  - grant_o=00 for exactly one cycle, then IDLE.
- m0 and m1 request on the same edge, each doing one write:
  - Fixed priority: order m0 then m1.
  - With WB_ARB_ROUND_ROBIN_EN, a second simultaneous pair is served m1 then m0.
  - One dead cycle between owners in both modes.
- m1 burst of 4 writes with cyc held high while m0 requests: m0 receives no grant until m1_cyc drops; then RELEASE, then OWN0.
- TIMEOUT_CYCLES=8, RAM never acks an m0 read:
  - m0_ack_o=1 with m0_dat_o=32'hDEAD_BEEF exactly 8 cycles after dfp_stb first rises.
  - timeout_o pulses once; dfp_cyc_o=0 in that cycle.
- TIMEOUT_CYCLES=8, RAM acks in the 8th cycle: normal ack with RAM data, timeout_o stays 0.
- wb_rst_i driven low while OWN1 is mid-transfer: next edge gives grant_o=0 and all dfp outputs 0, with no ack to m1.
